// File: rtl/j_acc_pkg.sv
// Shared definitions for the bit-serial accumulator link (serializer and deshifter).
package j_acc_pkg;

  localparam int WORD_W_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/j_serial_word_asm.sv
// Reassembles one LSB-first serial word: bit counter, indexed data register and
// a combinational completion strobe carrying the full word (final bit included).
module j_serial_word_asm
  import j_acc_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_active,
  input  logic              i_bit,
  input  logic              i_en,
  input  logic              i_start,
  input  logic              i_end,
  output logic              o_complete,
  output logic [WORD_W-1:0] o_word,
  output logic              o_start_err
);

  localparam int CNT_W = (clog2(WORD_W) < 1) ? 1 : clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_W - 1);

  logic [CNT_W-1:0]  r_bit_cnt;
  logic [WORD_W-1:0] r_data;
  logic              w_take;
  logic [CNT_W-1:0]  w_idx;
  logic [WORD_W-1:0] w_word;

  // A start marker restarts the word at bit 0 and drops whatever was partially received.
  always_comb begin
    w_take = i_active & i_en;
    w_idx  = i_start ? '0 : r_bit_cnt;
    w_word = i_start ? '0 : r_data;
    w_word[w_idx] = i_bit;
  end

  assign o_complete  = w_take & ((w_idx == LAST_IDX) | i_end);
  assign o_start_err = w_take & i_start & (r_bit_cnt != '0);
  assign o_word      = w_word;

  // Bit position and partial word; both return to zero once a word is handed off.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_bit_cnt <= '0;
      r_data    <= '0;
    end else if (w_take) begin
      if (o_complete) begin
        r_bit_cnt <= '0;
        r_data    <= '0;
      end else begin
        r_bit_cnt <= w_idx + 1'b1;
        r_data    <= w_word;
      end
    end
  end

endmodule

// File: rtl/j_acc_deshifter.sv
// Receive side of the bit-serial accumulator link: captures serial words and
// writes them to consecutive SRAM addresses for a job of img_size+1 words.
module j_acc_deshifter
  import j_acc_pkg::*;
#(
  parameter int SRAM_DEPTH  = 256 * 256 * 4,
  parameter int SRAM_ADDR_W = clog2(SRAM_DEPTH),
  parameter int WORD_W      = WORD_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   capture_start,
  output logic                   capture_idle,
  input  logic [SRAM_ADDR_W-1:0] start_addr,
  input  logic [SRAM_ADDR_W-1:0] img_size,
  input  logic                   serial_input,
  input  logic                   serial_en,
  input  logic                   serial_start,
  input  logic                   serial_end,
  output logic                   sram_wr_en,
  output logic [SRAM_ADDR_W-1:0] sram_wr_addr,
  output logic [WORD_W-1:0]      sram_wr_data,
  output logic                   frame_err
);

  state_t                 r_state;
  state_t                 w_state_n;
  logic                   w_accept;
  logic                   w_active;
  logic                   w_complete;
  logic                   w_start_err;
  logic [WORD_W-1:0]      w_word;
  logic [SRAM_ADDR_W-1:0] r_start_addr;
  logic [SRAM_ADDR_W-1:0] r_img_size;
  logic [SRAM_ADDR_W-1:0] r_word_idx;
  logic                   r_wr_en;
  logic [SRAM_ADDR_W-1:0] r_wr_addr;
  logic [WORD_W-1:0]      r_wr_data;
  logic                   r_frame_err;

  assign w_active = (r_state == S_RECV);

  j_serial_word_asm #(
    .WORD_W (WORD_W)
  ) u_asm (
    .clk         (clk),
    .reset       (reset),
    .i_clr       (w_accept),
    .i_active    (w_active),
    .i_bit       (serial_input),
    .i_en        (serial_en),
    .i_start     (serial_start),
    .i_end       (serial_end),
    .o_complete  (w_complete),
    .o_word      (w_word),
    .o_start_err (w_start_err)
  );

  // Job sequencing: the last word's completion moves to DONE, which lasts one cycle.
  always_comb begin
    w_state_n = r_state;
    w_accept  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (capture_start) begin
          w_state_n = S_RECV;
          w_accept  = 1'b1;
        end
      end
      S_RECV: begin
        if (w_complete && (r_word_idx == r_img_size)) w_state_n = S_DONE;
      end
      S_DONE:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_n;
  end

  // Job parameters, word index and the registered SRAM write port (address wraps silently).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_start_addr <= '0;
      r_img_size   <= '0;
      r_word_idx   <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
    end else begin
      r_wr_en <= w_complete;
      if (w_accept) begin
        r_start_addr <= start_addr;
        r_img_size   <= img_size;
        r_word_idx   <= '0;
      end else if (w_complete) begin
        r_word_idx <= r_word_idx + 1'b1;
      end
      if (w_complete) begin
        r_wr_addr <= r_start_addr + r_word_idx;
        r_wr_data <= w_word;
      end
    end
  end

  // Sticky framing error: stray bits outside a job or a restart mid-word; a new job clears it.
  always_ff @(posedge clk) begin
    if (reset)                           r_frame_err <= 1'b0;
    else if ((serial_en && !w_active) || w_start_err) r_frame_err <= 1'b1;
    else if (w_accept)                   r_frame_err <= 1'b0;
  end

  assign sram_wr_en   = r_wr_en;
  assign sram_wr_addr = r_wr_addr;
  assign sram_wr_data = r_wr_data;
  assign frame_err    = r_frame_err;
  assign capture_idle = (r_state == S_IDLE) & ~r_wr_en;

endmodule
